fft_real_loader: RTL and testbench

Input stage of the real FFT datapath. Accepts a stream of signed real samples over a valid/ready handshake and packs each even/odd sample pair into one complex word. It writes the 64 packed words of a frame into port A of the 64 x 2*WIDTH dual-port frame buffer, in bit-reversed address order. It then hands the full buffer to the FFT engine and stalls the stream until the engine acknowledges.

---
 rtl/fft_real_loader.sv | 136 +++++++++++++
 tb/tb_fft_real_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_real_loader.sv
// Real-sample input stage: packs even/odd sample pairs into complex words and
// writes a 64-word frame into buffer port A. Define FFT_LOADER_BITREV_EN for bit-reversed addressing.
module fft_real_loader #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [WIDTH-1:0]     In_Data,
    input  logic                 In_Last,
    output logic                 Ram_En,
    output logic                 Ram_We,
    output logic [5:0]           Ram_Addr,
    output logic [2*WIDTH-1:0]   Ram_DI,
    output logic                 Frame_Done,
    input  logic                 Frame_Ack,
    output logic                 Frame_Err
);

    typedef enum logic [1:0] {
        LOAD_EVEN = 2'd0,
        LOAD_ODD  = 2'd1,
        WAIT_ACK  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [6:0]           s_q, s_d;
    logic [5:0]           p_q, p_d;
    logic [WIDTH-1:0]     hold_q, hold_d;
    logic                 wr_q, wr_d;
    logic [5:0]           addr_q, addr_d;
    logic [2*WIDTH-1:0]   di_q, di_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 ready;
    logic                 accept;

`ifdef FFT_LOADER_BITREV_EN
    function automatic logic [5:0] pair_addr(input logic [5:0] v);
        return {v[0], v[1], v[2], v[3], v[4], v[5]};
    endfunction
`else
    function automatic logic [5:0] pair_addr(input logic [5:0] v);
        return v;
    endfunction
`endif

    assign ready  = (state_q != WAIT_ACK);
    assign accept = In_Valid & ready;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        p_d     = p_q;
        hold_d  = hold_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        di_d    = di_q;
        done_d  = 1'b0;
        err_d   = err_q;

        // Framing check is independent of state; counting proceeds regardless.
        if (accept) begin
            s_d = s_q + 7'd1;
            if (In_Last != (s_q == 7'd127))
                err_d = 1'b1;
        end

        case (state_q)
            LOAD_EVEN: begin
                if (accept) begin
                    hold_d  = In_Data;
                    state_d = LOAD_ODD;
                end
            end
            LOAD_ODD: begin
                if (accept) begin
                    wr_d   = 1'b1;
                    addr_d = pair_addr(p_q);
                    di_d   = {hold_q, In_Data};
                    p_d    = p_q + 6'd1;
                    if (p_q == 6'd63) begin
                        done_d  = 1'b1;
                        state_d = WAIT_ACK;
                    end else begin
                        state_d = LOAD_EVEN;
                    end
                end
            end
            WAIT_ACK: begin
                if (Frame_Ack) begin
                    p_d     = '0;
                    s_d     = '0;
                    state_d = LOAD_EVEN;
                end
            end
            default: state_d = LOAD_EVEN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= LOAD_EVEN;
            s_q     <= '0;
            p_q     <= '0;
            hold_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            di_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            p_q     <= p_d;
            hold_q  <= hold_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Outputs are forced to their reset values for every cycle Rst is high,
    // including the first one, before the registers have been cleared.
    assign In_Ready   = ready & ~Rst;
    assign Ram_En     = wr_q & ~Rst;
    assign Ram_We     = wr_q & ~Rst;
    assign Ram_Addr   = Rst ? '0 : addr_q;
    assign Ram_DI     = Rst ? '0 : di_q;
    assign Frame_Done = done_q & ~Rst;
    assign Frame_Err  = err_q & ~Rst;

endmodule

// File: tb/tb_fft_real_loader.sv
// Directed bench for fft_real_loader; expected addresses follow FFT_LOADER_BITREV_EN.
module tb_fft_real_loader;

    localparam int unsigned WIDTH = 32;

    logic               Clk;
    logic               Rst;
    logic               In_Valid;
    logic               In_Ready;
    logic [WIDTH-1:0]   In_Data;
    logic               In_Last;
    logic               Ram_En;
    logic               Ram_We;
    logic [5:0]         Ram_Addr;
    logic [2*WIDTH-1:0] Ram_DI;
    logic               Frame_Done;
    logic               Frame_Ack;
    logic               Frame_Err;

    int chk  = 0;
    int errs = 0;

    int wr_total   = 0;
    int done_total = 0;
    logic [2*WIDTH-1:0] mem [64];

    fft_real_loader #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Data(In_Data), .In_Last(In_Last), .Ram_En(Ram_En), .Ram_We(Ram_We),
        .Ram_Addr(Ram_Addr), .Ram_DI(Ram_DI), .Frame_Done(Frame_Done),
        .Frame_Ack(Frame_Ack), .Frame_Err(Frame_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Buffer port A model: records every write and every done pulse.
    always @(negedge Clk) begin
        if (Ram_En && Ram_We) begin
            wr_total      <= wr_total + 1;
            mem[Ram_Addr] <= Ram_DI;
        end
        if (Frame_Done)
            done_total <= done_total + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] exp_addr(input int unsigned k);
        logic [5:0] v;
        v = k[5:0];
`ifdef FFT_LOADER_BITREV_EN
        return {v[0], v[1], v[2], v[3], v[4], v[5]};
`else
        return v;
`endif
    endfunction

    function automatic logic [2*WIDTH-1:0] pack(input int unsigned e, input int unsigned o);
        logic [WIDTH-1:0] ev, od;
        ev = e;
        od = o;
        return {ev, od};
    endfunction

    // Presents one sample and returns #1 after the edge that accepted it.
    task automatic send(input int unsigned d, input logic last);
        int unsigned n;
        In_Valid = 1'b1;
        In_Data  = d;
        In_Last  = last;
        n = 0;
        @(negedge Clk);
        while (!In_Ready && n < 64) begin
            n++;
            @(negedge Clk);
        end
        if (!In_Ready) begin
            chk++; errs++;
            $display("FAIL send_timeout data=%0d ready=%b required=1", d, In_Ready);
        end
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        In_Last  = 1'b0;
    endtask

    task automatic pulse_ack();
        Frame_Ack = 1'b1;
        @(posedge Clk);
        #1;
        Frame_Ack = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; In_Valid = 1'b0; In_Data = '0; In_Last = 1'b0; Frame_Ack = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk++; if (In_Ready !== 1'b0)  begin errs++; $display("FAIL rst_ready got=%b want=0", In_Ready); end
        chk++; if (Ram_En !== 1'b0)    begin errs++; $display("FAIL rst_en got=%b want=0", Ram_En); end
        chk++; if (Ram_We !== 1'b0)    begin errs++; $display("FAIL rst_we got=%b want=0", Ram_We); end
        chk++; if (Ram_Addr !== 6'd0)  begin errs++; $display("FAIL rst_addr got=%0d want=0", Ram_Addr); end
        chk++; if (Ram_DI !== 64'd0)   begin errs++; $display("FAIL rst_di got=%h want=0", Ram_DI); end
        chk++; if (Frame_Done !== 1'b0) begin errs++; $display("FAIL rst_done got=%b want=0", Frame_Done); end
        chk++; if (Frame_Err !== 1'b0) begin errs++; $display("FAIL rst_err got=%b want=0", Frame_Err); end
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        chk++; if (In_Ready !== 1'b1)  begin errs++; $display("FAIL rst_release_ready got=%b want=1", In_Ready); end
    endtask

    task automatic test_ramp_frame();
        int base_wr, base_done;
        base_wr = wr_total; base_done = done_total;
        for (int i = 0; i < 128; i++) begin
            send(i, i == 127);
            if (i == 3) begin
                chk++; if (Ram_En !== 1'b1) begin errs++; $display("FAIL ramp_p1_en got=%b want=1", Ram_En); end
                chk++; if (Ram_Addr !== exp_addr(1)) begin errs++; $display("FAIL ramp_p1_addr got=%0d want=%0d", Ram_Addr, exp_addr(1)); end
                chk++; if (Ram_DI !== pack(2, 3)) begin errs++; $display("FAIL ramp_p1_di got=%h want=%h", Ram_DI, pack(2, 3)); end
            end
        end
        chk++; if (Ram_En !== 1'b1) begin errs++; $display("FAIL ramp_p63_en got=%b want=1", Ram_En); end
        chk++; if (Ram_Addr !== 6'd63) begin errs++; $display("FAIL ramp_p63_addr got=%0d want=63", Ram_Addr); end
        chk++; if (Ram_DI !== pack(126, 127)) begin errs++; $display("FAIL ramp_p63_di got=%h want=%h", Ram_DI, pack(126, 127)); end
        chk++; if (Frame_Done !== 1'b1) begin errs++; $display("FAIL ramp_done got=%b want=1", Frame_Done); end
        chk++; if (In_Ready !== 1'b0) begin errs++; $display("FAIL ramp_waitack_ready got=%b want=0", In_Ready); end
        @(posedge Clk);
        #1;
        chk++; if (Frame_Done !== 1'b0) begin errs++; $display("FAIL ramp_done_pulse got=%b want=0", Frame_Done); end
        chk++; if (wr_total - base_wr !== 64) begin errs++; $display("FAIL ramp_writes got=%0d want=64", wr_total - base_wr); end
        chk++; if (done_total - base_done !== 1) begin errs++; $display("FAIL ramp_done_count got=%0d want=1", done_total - base_done); end
        chk++; if (mem[exp_addr(40)] !== pack(80, 81)) begin errs++; $display("FAIL ramp_mem40 got=%h want=%h", mem[exp_addr(40)], pack(80, 81)); end
        chk++; if (mem[exp_addr(1)] !== pack(2, 3)) begin errs++; $display("FAIL ramp_mem1 got=%h want=%h", mem[exp_addr(1)], pack(2, 3)); end
        chk++; if (Frame_Err !== 1'b0) begin errs++; $display("FAIL ramp_err got=%b want=0", Frame_Err); end
    endtask

    task automatic test_backpressure();
        int base_wr, base_done;
        base_wr = wr_total; base_done = done_total;
        In_Valid = 1'b1; In_Data = 1000;
        for (int c = 0; c < 20; c++) begin
            @(posedge Clk);
            #1;
            chk++; if (In_Ready !== 1'b0) begin errs++; $display("FAIL hold_ready cyc=%0d got=%b want=0", c, In_Ready); end
            chk++; if (Ram_En !== 1'b0) begin errs++; $display("FAIL hold_en cyc=%0d got=%b want=0", c, Ram_En); end
        end
        pulse_ack();
        chk++; if (In_Ready !== 1'b1) begin errs++; $display("FAIL ack_ready got=%b want=1", In_Ready); end
        chk++; if (wr_total !== base_wr) begin errs++; $display("FAIL hold_writes got=%0d want=%0d", wr_total, base_wr); end
        for (int i = 0; i < 128; i++)
            send(1000 + i, i == 127);
        chk++; if (Frame_Done !== 1'b1) begin errs++; $display("FAIL bp_done got=%b want=1", Frame_Done); end
        chk++; if (Ram_DI !== pack(1126, 1127)) begin errs++; $display("FAIL bp_p63_di got=%h want=%h", Ram_DI, pack(1126, 1127)); end
        // Ack issued in the Frame_Done cycle itself
        pulse_ack();
        chk++; if (In_Ready !== 1'b1) begin errs++; $display("FAIL concurrent_ack_ready got=%b want=1", In_Ready); end
        chk++; if (mem[exp_addr(0)] !== pack(1000, 1001)) begin errs++; $display("FAIL bp_mem0 got=%h want=%h", mem[exp_addr(0)], pack(1000, 1001)); end
        chk++; if (done_total - base_done !== 1) begin errs++; $display("FAIL bp_done_count got=%0d want=1", done_total - base_done); end
        chk++; if (wr_total - base_wr !== 64) begin errs++; $display("FAIL bp_writes got=%0d want=64", wr_total - base_wr); end
    endtask

    task automatic test_valid_gaps();
        int base_wr;
        base_wr = wr_total;
        for (int i = 0; i < 128; i++) begin
            if (i == 11) begin
                repeat (7) @(posedge Clk);
                #1;
                chk++; if (Ram_En !== 1'b0) begin errs++; $display("FAIL gap_en got=%b want=0", Ram_En); end
                chk++; if (In_Ready !== 1'b1) begin errs++; $display("FAIL gap_ready got=%b want=1", In_Ready); end
            end
            send(i, i == 127);
            if (i == 11) begin
                chk++; if (Ram_En !== 1'b1) begin errs++; $display("FAIL gap_p5_en got=%b want=1", Ram_En); end
                chk++; if (Ram_Addr !== exp_addr(5)) begin errs++; $display("FAIL gap_p5_addr got=%0d want=%0d", Ram_Addr, exp_addr(5)); end
                chk++; if (Ram_DI !== pack(10, 11)) begin errs++; $display("FAIL gap_p5_di got=%h want=%h", Ram_DI, pack(10, 11)); end
            end
        end
        chk++; if (Frame_Done !== 1'b1) begin errs++; $display("FAIL gap_done got=%b want=1", Frame_Done); end
        pulse_ack();
        chk++; if (wr_total - base_wr !== 64) begin errs++; $display("FAIL gap_writes got=%0d want=64", wr_total - base_wr); end
        chk++; if (Frame_Err !== 1'b0) begin errs++; $display("FAIL gap_err got=%b want=0", Frame_Err); end
    endtask

    task automatic test_framing_error();
        int base_wr;
        base_wr = wr_total;
        for (int i = 0; i < 128; i++) begin
            send(300 + i, i == 50);
            if (i == 49) begin
                chk++; if (Frame_Err !== 1'b0) begin errs++; $display("FAIL ferr_before got=%b want=0", Frame_Err); end
            end
            if (i == 50) begin
                chk++; if (Frame_Err !== 1'b1) begin errs++; $display("FAIL ferr_set got=%b want=1", Frame_Err); end
            end
        end
        chk++; if (Frame_Done !== 1'b1) begin errs++; $display("FAIL ferr_done got=%b want=1", Frame_Done); end
        chk++; if (Ram_DI !== pack(426, 427)) begin errs++; $display("FAIL ferr_p63_di got=%h want=%h", Ram_DI, pack(426, 427)); end
        pulse_ack();
        @(posedge Clk);
        #1;
        chk++; if (wr_total - base_wr !== 64) begin errs++; $display("FAIL ferr_writes got=%0d want=64", wr_total - base_wr); end
        chk++; if (Frame_Err !== 1'b1) begin errs++; $display("FAIL ferr_sticky got=%b want=1", Frame_Err); end
    endtask

    task automatic test_reset_midframe();
        int base_wr;
        for (int i = 0; i < 37; i++)
            send(200 + i, 1'b0);
        Rst = 1'b1; In_Valid = 1'b1; In_Data = 999;
        #1;
        chk++; if (In_Ready !== 1'b0) begin errs++; $display("FAIL mid_rst_ready got=%b want=0", In_Ready); end
        chk++; if (Ram_En !== 1'b0) begin errs++; $display("FAIL mid_rst_en got=%b want=0", Ram_En); end
        chk++; if (Ram_DI !== 64'd0) begin errs++; $display("FAIL mid_rst_di got=%h want=0", Ram_DI); end
        chk++; if (Frame_Err !== 1'b0) begin errs++; $display("FAIL mid_rst_err got=%b want=0", Frame_Err); end
        @(posedge Clk);
        #1;
        chk++; if (Ram_Addr !== 6'd0) begin errs++; $display("FAIL mid_rst_addr got=%0d want=0", Ram_Addr); end
        chk++; if (Frame_Done !== 1'b0) begin errs++; $display("FAIL mid_rst_done got=%b want=0", Frame_Done); end
        Rst = 1'b0; In_Valid = 1'b0;
        base_wr = wr_total;
        send(500, 1'b0);
        send(501, 1'b0);
        chk++; if (Ram_En !== 1'b1) begin errs++; $display("FAIL mid_p0_en got=%b want=1", Ram_En); end
        chk++; if (Ram_Addr !== 6'd0) begin errs++; $display("FAIL mid_p0_addr got=%0d want=0", Ram_Addr); end
        chk++; if (Ram_DI !== pack(500, 501)) begin errs++; $display("FAIL mid_p0_di got=%h want=%h", Ram_DI, pack(500, 501)); end
        send(502, 1'b0);
        send(503, 1'b0);
        chk++; if (Ram_Addr !== exp_addr(1)) begin errs++; $display("FAIL mid_p1_addr got=%0d want=%0d", Ram_Addr, exp_addr(1)); end
        @(posedge Clk);
        #1;
        chk++; if (wr_total - base_wr !== 2) begin errs++; $display("FAIL mid_writes got=%0d want=2", wr_total - base_wr); end
        chk++; if (Frame_Err !== 1'b0) begin errs++; $display("FAIL mid_err got=%b want=0", Frame_Err); end
    endtask

    initial begin
        test_reset();
        test_ramp_frame();
        test_backpressure();
        test_valid_gaps();
        test_framing_error();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", chk, errs);
        $finish;
    end

endmodule
